vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Scan generator driving the sprite renderers: produces DrawX/DrawY, blank (1 = visible) and hs/vs.
//  Adds copies of blank/hs/vs delayed by PIPE_DLY cycles to match the renderers' ROM-read + colour-register pipeline.
//  Also emits line/frame strobes and a frame counter for animation logic.
// PARAMETERS
//  H_VISIBLE 640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels); H_TOTAL = sum of H_* = 800
//  V_VISIBLE 480  visible lines
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines); V_TOTAL = sum of V_* = 525
//  PIPE_DLY  1    delay of hs_d/vs_d/blank_d vs. DrawX/DrawY (0..7; 0 = pass-through)
// PORTS
//  vga_clk      in   1   pixel clock; everything on posedge
//  reset_n      in   1   async active-low reset
//  DrawX        out  10  current horizontal count, 0..H_TOTAL-1
//  DrawY        out  10  current vertical count, 0..V_TOTAL-1
//  blank        out  1   1 when DrawX<H_VISIBLE and DrawY<V_VISIBLE
//  hs           out  1   horizontal sync, active-low
//  vs           out  1   vertical sync, active-low
//  blank_d      out  1   blank delayed PIPE_DLY cycles
//  hs_d         out  1   hs delayed PIPE_DLY cycles
//  vs_d         out  1   vs delayed PIPE_DLY cycles
//  line_start   out  1   1-cycle pulse when DrawX==0 (any line)
//  frame_start  out  1   1-cycle pulse when DrawX==0 and DrawY==0
//  frame_count  out  16  frames completed since reset; wraps 65535->0
// BEHAVIOUR
//  - Reset (async assert, sync release): DrawX=0, DrawY=0, blank=0, hs=1, vs=1, line_start=0,
//    frame_start=0, frame_count=0; every delay-stage register: blank=0, hs=1, vs=1.
//  - Horizontal counter:
//    - counter advances one per vga_clk from the first edge after release;
//    - DrawX wraps H_TOTAL-1 -> 0.
//  - Vertical counter:
//    - DrawY increments only on the DrawX wrap;
//    - DrawY wraps V_TOTAL-1 -> 0 on the same edge that DrawX wraps.
//  - Registered status outputs:
//    - blank/hs/vs/line_start/frame_start are registers decoded from the next count;
//    - hence always valid for the DrawX/DrawY shown in the same cycle, except during reset.
//  - First pixel after reset: (0,0) is blanked (blank=0 reset value); frame_start is not pulsed until the first wrap.
//  - hs=0 for DrawX in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] (656..751 default).
//  - vs=0 for DrawY in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] (490..491), whole lines.
//  - frame_count increments on the same edge frame_start rises; mod 2^16.
//  - Delay lines:
//    - PIPE_DLY-deep shift registers, so blank_d(t) = blank(t-PIPE_DLY), same for hs/vs;
//    - within PIPE_DLY cycles after reset they carry the reset values.
//  - Arithmetic: counters 10-bit unsigned; compare against localparam totals; no overflow beyond wrap.
//  - Reset mid-frame: all state returns to reset values asynchronously; scan restarts at (0,0).
// TESTING
//  1 Reset asserted at DrawX=300,DrawY=200 -> all outputs at reset values same cycle; after release DrawX counts 0,1,2.
//  2 Hsync: hs falls when DrawX=656, rises at DrawX=752 (96 low cycles); line_start every 800 cycles.
//  3 Vsync: vs low from (0,490) to (799,491) = 1600 cycles; high elsewhere.
//  4 Frames: frame_start pulses every 420000 cycles; frame_count 0->1->2 over two frames.
//  5 Blank edges: blank=1 at (639,479), 0 at (640,479) and (0,480); 1 again at (0,0) of next frame.
//  6 PIPE_DLY=3 with H=8/2/2/2, V=4/1/1/1: blank_d/hs_d/vs_d equal originals shifted 3 cycles; wrap at (13,6)->(0,0); frame_count wraps after 65536 frames.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA scan generator: pixel/line counters, registered blank/sync decode,
// delayed copies of the status bits for the sprite pipeline, and frame strobes.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        blank_d,
  output logic        hs_d,
  output logic        vs_d,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] next_x;
  logic [9:0] next_y;

  always_comb begin
    next_x = DrawX + 10'd1;
    next_y = DrawY;
    if (DrawX == H_MAX) begin
      next_x = '0;
      if (DrawY == V_MAX) next_y = '0;
      else                next_y = DrawY + 10'd1;
    end
  end

  // Status bits are decoded from the upcoming count so they line up with
  // the DrawX/DrawY value presented in the same cycle.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= next_x;
      DrawY       <= next_y;
      blank       <= (next_x < H_VIS) && (next_y < V_VIS);
      hs          <= !((next_x >= HS_FIRST) && (next_x <= HS_LAST));
      vs          <= !((next_y >= VS_FIRST) && (next_y <= VS_LAST));
      line_start  <= (next_x == '0);
      frame_start <= (next_x == '0) && (next_y == '0);
      if ((next_x == '0) && (next_y == '0))
        frame_count <= frame_count + 16'd1;
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_no_delay
      assign blank_d = blank;
      assign hs_d    = hs;
      assign vs_d    = vs;
    end else begin : g_delay
      logic [PIPE_DLY-1:0] blank_sr;
      logic [PIPE_DLY-1:0] hs_sr;
      logic [PIPE_DLY-1:0] vs_sr;

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          blank_sr <= '0;
          hs_sr    <= '1;
          vs_sr    <= '1;
        end else begin
          blank_sr[0] <= blank;
          hs_sr[0]    <= hs;
          vs_sr[0]    <= vs;
          for (int i = 1; i < PIPE_DLY; i++) begin
            blank_sr[i] <= blank_sr[i-1];
            hs_sr[i]    <= hs_sr[i-1];
            vs_sr[i]    <= vs_sr[i-1];
          end
        end
      end

      assign blank_d = blank_sr[PIPE_DLY-1];
      assign hs_d    = hs_sr[PIPE_DLY-1];
      assign vs_d    = vs_sr[PIPE_DLY-1];
    end
  endgenerate

endmodule
